// File: rtl/mem_access_if.sv
// Bundle of CPU-side load/store request signals and the data-memory port
// that mem_access_unit sits between. The unit uses the slave modport;
// the CPU / memory side (or a bench) uses the master modport.
interface mem_access_if;
    // CPU memory-stage request
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // CPU-facing responses
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        misalign;
    // data memory port
    logic        mem_wr;
    logic        mem_oe;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  mem_dout,
        output stall, load_valid, load_data, misalign,
        output mem_wr, mem_oe, mem_addr, mem_din
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output mem_dout,
        input  stall, load_valid, load_data, misalign,
        input  mem_wr, mem_oe, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences byte/halfword/word loads and stores from the
// CPU memory stage onto a word-wide data memory with a one-cycle read.
// Sub-word stores are done as read-modify-write. Lanes are big-endian.
//
// Optional build macro MISALIGN_TRAP_EN: when defined, misaligned halfword
// and word requests go straight to DONE with a misalign pulse and no memory
// access. When undefined, the low address bits below the access size are
// simply ignored and misalign stays 0.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a request; latches it on req_valid
// RD    | mem_oe asserted, reading the aligned word
// CAP   | mem_dout captured: load result extracted or store word merged
// WR    | mem_wr asserted with the write buffer
// DONE  | one-cycle completion; load_valid for loads, never accepts
module mem_access_unit (
    input  logic          clk,
    input  logic          rst,
    mem_access_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state_q;

    // latched request fields still needed after the accept cycle
    logic        write_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;

    // registered outputs
    logic        mem_oe_q;
    logic        mem_wr_q;
    logic        load_valid_q;
    logic        misalign_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_din_q;
    logic [31:0] load_data_q;

    // combinational helpers feeding the FSM
    logic        misaligned_d;
    logic [7:0]  rd_byte_d;
    logic [15:0] rd_half_d;
    logic [31:0] load_ext_d;
    logic [31:0] merge_d;

    // Misaligned-request detection on the incoming request
`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misaligned_d = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                       (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
    end
`else
    assign misaligned_d = 1'b0;
`endif

    // Big-endian lane selection and sign/zero extension of the read word
    always_comb begin
        rd_byte_d  = 8'h00;
        rd_half_d  = 16'h0000;
        load_ext_d = bus.mem_dout;
        case (off_q)
            2'd0:    rd_byte_d = bus.mem_dout[31:24];
            2'd1:    rd_byte_d = bus.mem_dout[23:16];
            2'd2:    rd_byte_d = bus.mem_dout[15:8];
            default: rd_byte_d = bus.mem_dout[7:0];
        endcase
        rd_half_d = off_q[1] ? bus.mem_dout[15:0] : bus.mem_dout[31:16];
        case (size_q)
            2'b00:   load_ext_d = {{24{signed_q & rd_byte_d[7]}}, rd_byte_d};
            2'b01:   load_ext_d = {{16{signed_q & rd_half_d[15]}}, rd_half_d};
            default: load_ext_d = bus.mem_dout;
        endcase
    end

    // Merge sub-word store data into the addressed lane of the read word
    always_comb begin
        merge_d = bus.mem_dout;
        if (size_q == 2'b00) begin
            case (off_q)
                2'd0:    merge_d[31:24] = wdata_q[7:0];
                2'd1:    merge_d[23:16] = wdata_q[7:0];
                2'd2:    merge_d[15:8]  = wdata_q[7:0];
                default: merge_d[7:0]   = wdata_q[7:0];
            endcase
        end else begin
            if (off_q[1]) begin
                merge_d[15:0]  = wdata_q;
            end else begin
                merge_d[31:16] = wdata_q;
            end
        end
    end

    // Main sequencer with registered memory strobes and responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            wdata_q      <= 16'h0000;
            mem_oe_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            load_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_din_q    <= 32'h0;
            load_data_q  <= 32'h0;
        end else begin
            // strobes are single-cycle unless a transition below re-asserts them
            mem_oe_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            load_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_q  <= bus.req_write;
                        signed_q <= bus.req_signed;
                        size_q   <= bus.req_size;
                        off_q    <= bus.req_addr[1:0];
                        wdata_q  <= bus.req_wdata[15:0];
                        if (misaligned_d) begin
                            misalign_q <= 1'b1;
                            state_q    <= DONE;
                        end else if (bus.req_write && bus.req_size[1]) begin
                            // full-word store needs no read
                            mem_wr_q   <= 1'b1;
                            mem_addr_q <= {bus.req_addr[31:2], 2'b00};
                            mem_din_q  <= bus.req_wdata;
                            state_q    <= WR;
                        end else begin
                            mem_oe_q   <= 1'b1;
                            mem_addr_q <= {bus.req_addr[31:2], 2'b00};
                            state_q    <= RD;
                        end
                    end
                end
                RD: begin
                    state_q <= CAP;
                end
                CAP: begin
                    if (write_q) begin
                        mem_din_q <= merge_d;
                        mem_wr_q  <= 1'b1;
                        state_q   <= WR;
                    end else begin
                        load_data_q  <= load_ext_d;
                        load_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                WR: begin
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // stall is the only output that must react to req_valid in the same cycle
    always_comb begin
        bus.stall = (state_q != DONE) && (bus.req_valid || (state_q != IDLE));
    end

    assign bus.mem_oe     = mem_oe_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.load_valid = load_valid_q;
    assign bus.misalign   = misalign_q;
    assign bus.load_data  = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_if bus();

    mem_access_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- data memory seen by the DUT ----------------
    logic [31:0] mem [64];
    logic        bd_we;
    logic [5:0]  bd_idx;
    logic [31:0] bd_val;

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_val;
        if (bus.mem_oe) bus.mem_dout <= mem[bus.mem_addr[7:2]];
        if (bus.mem_wr) mem[bus.mem_addr[7:2]] <= bus.mem_din;
    end

    // ---------------- reference model state ----------------
    logic [31:0] ref_mem [64];
    logic [31:0] model_ld;

    typedef struct {
        logic        stall;
        logic        oe;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] din;
        logic        lv;
        logic        mis;
        logic [31:0] ld;
    } exp_t;

    exp_t        expq[$];
    exp_t        cur;
    logic [31:0] cmp_ld;
    logic        cmp_en;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic st, input logic oe, input logic wr,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic lv, input logic mis, input logic [31:0] ld);
        exp_t e;
        e.stall = st; e.oe = oe; e.wr = wr; e.addr = a; e.din = d;
        e.lv = lv; e.mis = mis; e.ld = ld;
        return e;
    endfunction

    // big-endian lane extraction with extension
    function automatic logic [31:0] ld_val(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sg, input logic [1:0] off);
        int sh;
        logic [31:0] r;
        if (sz == 2'b00) begin
            sh = 8 * (3 - int'(off));
            r = (w >> sh) & 32'hFF;
            if (sg && r[7]) r = r | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            sh = 16 * (1 - int'(off[1]));
            r = (w >> sh) & 32'hFFFF;
            if (sg && r[15]) r = r | 32'hFFFF_0000;
        end else begin
            r = w;
        end
        return r;
    endfunction

    function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [31:0] wd, input logic [1:0] off);
        int sh;
        if (sz == 2'b00) begin
            sh = 8 * (3 - int'(off));
            return (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        end
        sh = 16 * (1 - int'(off[1]));
        return (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
    endfunction

    function automatic logic is_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        return ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
`else
        return 1'b0;
`endif
    endfunction

    // Issue one request (called just after a rising edge); pushes the
    // expected per-cycle outputs and runs until the unit is back in IDLE.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] w, al, ld0, r;
        int n;
        w   = ref_mem[a[7:2]];
        al  = {a[31:2], 2'b00};
        ld0 = model_ld;
        if (is_mis(sz, a)) begin
            n = 2;
            expq.push_back(mk(1, 0, 0, 0, 0, 0, 0, ld0));
            expq.push_back(mk(0, 0, 0, 0, 0, 0, 1, ld0));
        end else if (!wr) begin
            n = 4;
            r = ld_val(w, sz, sg, a[1:0]);
            expq.push_back(mk(1, 0, 0, 0,  0, 0, 0, ld0));
            expq.push_back(mk(1, 1, 0, al, 0, 0, 0, ld0));
            expq.push_back(mk(1, 0, 0, 0,  0, 0, 0, ld0));
            expq.push_back(mk(0, 0, 0, 0,  0, 1, 0, r));
            model_ld = r;
        end else if (sz[1]) begin
            n = 3;
            expq.push_back(mk(1, 0, 0, 0,  0,  0, 0, ld0));
            expq.push_back(mk(1, 0, 1, al, wd, 0, 0, ld0));
            expq.push_back(mk(0, 0, 0, 0,  0,  0, 0, ld0));
            ref_mem[a[7:2]] = wd;
        end else begin
            n = 5;
            r = st_merge(w, sz, wd, a[1:0]);
            expq.push_back(mk(1, 0, 0, 0,  0, 0, 0, ld0));
            expq.push_back(mk(1, 1, 0, al, 0, 0, 0, ld0));
            expq.push_back(mk(1, 0, 0, 0,  0, 0, 0, ld0));
            expq.push_back(mk(1, 0, 1, al, r, 0, 0, ld0));
            expq.push_back(mk(0, 0, 0, 0,  0, 0, 0, ld0));
            ref_mem[a[7:2]] = r;
        end
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        repeat (n - 1) @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Per-cycle compare of every DUT output against the model's expectation
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            if (expq.size() > 0) cur = expq.pop_front();
            else                 cur = mk(bus.req_valid, 0, 0, 0, 0, 0, 0, cmp_ld);
            chk("stall",      bus.stall,      cur.stall);
            chk("mem_oe",     bus.mem_oe,     cur.oe);
            chk("mem_wr",     bus.mem_wr,     cur.wr);
            chk("load_valid", bus.load_valid, cur.lv);
            chk("misalign",   bus.misalign,   cur.mis);
            chk("load_data",  bus.load_data,  cur.ld);
            if (cur.oe || cur.wr) chk("mem_addr", bus.mem_addr, cur.addr);
            if (cur.wr)           chk("mem_din",  bus.mem_din,  cur.din);
            cmp_ld = cur.ld;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] saved;

    initial begin
        cmp_en = 1'b0;
        cmp_ld = 32'h0;
        model_ld = 32'h0;
        bd_we = 1'b0; bd_idx = '0; bd_val = '0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        rst = 1'b1;
        #2;
        // reset values, before any clock edge
        chk("rst_stall",      bus.stall,      0);
        chk("rst_mem_oe",     bus.mem_oe,     0);
        chk("rst_mem_wr",     bus.mem_wr,     0);
        chk("rst_load_valid", bus.load_valid, 0);
        chk("rst_misalign",   bus.misalign,   0);
        chk("rst_load_data",  bus.load_data,  0);
        chk("rst_mem_addr",   bus.mem_addr,   0);
        chk("rst_mem_din",    bus.mem_din,    0);

        // preload memory through the backdoor while in reset
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            bd_we  = 1'b1;
            bd_idx = 6'(i);
            bd_val = (i == 16) ? 32'h8899_AABB : $urandom;
            ref_mem[i] = bd_val;
        end
        @(negedge clk);
        bd_we = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1 cmp_en = 1'b1;

        // directed cases around word 0x40 = 0x8899AABB
        issue(0, 2'b00, 1, 32'h41, 32'h0);
        chk("pin_lb_signed_0x41", model_ld, 32'hFFFF_FF99);
        issue(0, 2'b01, 0, 32'h42, 32'h0);
        chk("pin_lh_unsigned_0x42", model_ld, 32'h0000_AABB);
        issue(0, 2'b01, 1, 32'h40, 32'h0);
        chk("pin_lh_signed_0x40", model_ld, 32'hFFFF_8899);
        issue(1, 2'b00, 0, 32'h43, 32'h12);
        chk("pin_sb_merge", ref_mem[16], 32'h8899_AA12);
        chk("mem_after_sb", mem[16], 32'h8899_AA12);
        issue(1, 2'b10, 0, 32'h80, 32'hDEAD_BEEF);
        chk("mem_after_sw", mem[32], 32'hDEAD_BEEF);
        issue(0, 2'b10, 0, 32'h42, 32'h0);
`ifdef MISALIGN_TRAP_EN
        chk("pin_lw_misaligned_keeps", model_ld, 32'hFFFF_8899);
`else
        chk("pin_lw_ignores_low_bits", model_ld, 32'h8899_AA12);
`endif
        issue(0, 2'b11, 0, 32'h80, 32'h0);
        chk("pin_size3_is_word", model_ld, 32'hDEAD_BEEF);

        // reset pulsed while a halfword store is in RD
        cmp_en = 1'b0;
        saved = mem[17];
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b01;
        bus.req_signed = 1'b0; bus.req_addr = 32'h44; bus.req_wdata = 32'h5555;
        @(negedge clk);
        chk("rstwr_accept_stall", bus.stall, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstwr_rd_oe", bus.mem_oe, 1);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstwr_mem_oe",     bus.mem_oe,     0);
        chk("rstwr_mem_wr",     bus.mem_wr,     0);
        chk("rstwr_stall",      bus.stall,      0);
        chk("rstwr_load_data",  bus.load_data,  0);
        chk("rstwr_mem_addr",   bus.mem_addr,   0);
        chk("rstwr_mem_din",    bus.mem_din,    0);
        @(negedge clk);
        rst = 1'b0;
        model_ld = 32'h0;
        cmp_ld = 32'h0;
        @(posedge clk);
        #1 cmp_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rstwr_mem_unchanged", mem[17], saved);
        // unit must be back in IDLE and serve a fresh request normally
        issue(0, 2'b10, 0, 32'h44, 32'h0);
        chk("pin_after_reset_load", model_ld, saved);

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", expq.size(), 0);
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("final_mem[%0d]", i), mem[i], ref_mem[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have no parameters; all widths are fixed at 32-bit data and 32-bit byte address.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  load/store request from the CPU memory stage; held stable while stall=1.
REQ-005 req_write  in  1  1 = store, 0 = load.
REQ-006 req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = treated as word.
REQ-007 req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-justified for byte and halfword.
REQ-010 stall  out  1  freeze the CPU pipeline.
REQ-011 load_valid  out  1  one-cycle pulse; load_data is valid.
REQ-012 load_data  out  32  aligned and extended load result.
REQ-013 misalign  out  1  one-cycle fault pulse; see Configuration.
REQ-014 mem_wr  out  1  drives data memory MemWr.
REQ-015 mem_oe  out  1  drives data memory output_en.
REQ-016 mem_addr  out  32  word-aligned address to data memory: {addr[31:2],2'b00}.
REQ-017 mem_din  out  32  write data to data memory.
REQ-018 mem_dout  in  32  data memory read data, valid one cycle after a cycle with mem_oe=1.

Function
REQ-019 SHALL implement the FSM states IDLE, RD, CAP, WR and DONE.
REQ-020 IDLE with req_valid=1 SHALL latch the request (addr, size, signed, wdata) and transition as follows.
  - Load -> RD.
  - Word store -> WR.
  - Byte or halfword store -> RD.
REQ-021 RD: mem_oe=1 and mem_addr=latched aligned address; next state is CAP.
REQ-022 CAP SHALL register mem_dout.
  - Load: extract and extend the addressed lane into the result register; next state is DONE.
  - Sub-word store: merge wdata into the addressed lane of the read word to form the write buffer; next state is WR.
REQ-023 WR: mem_wr=1, mem_din=write buffer (or wdata for a word store), mem_addr=aligned address; next state is DONE.
REQ-024 DONE: load_valid=1 for loads only; next state is IDLE; DONE SHALL NOT accept a request.
REQ-025 Lane ordering SHALL be big-endian.
  - Byte offset 0 = bits[31:24], byte offset 3 = bits[7:0].
  - Halfword offset 0 = bits[31:16].
REQ-026 stall = (state != DONE) && (req_valid || state != IDLE).
REQ-027 Latency from the accept cycle to DONE SHALL be:
  - load: 3 cycles;
  - word store: 2 cycles;
  - sub-word store: 4 cycles.
REQ-028 mem_wr and mem_oe SHALL never be high in the same cycle, and SHALL be 0 in IDLE, CAP and DONE.
REQ-029 load_data SHALL hold its last value until the next load completes.

Reset
REQ-030 rst=1 SHALL immediately force the following values, regardless of clk:
  - state=IDLE;
  - mem_wr=0, mem_oe=0, stall=0 (when req_valid=0);
  - load_valid=0, misalign=0;
  - load_data=0, mem_addr=0, mem_din=0.
REQ-031 Reset in WR SHALL abort the write with no further memory cycle.
REQ-032 Reset in any other state SHALL discard the pending request; the CPU re-issues it.

Configuration
REQ-033 Macro MISALIGN_TRAP_EN SHALL control misaligned-access handling.
REQ-034 With MISALIGN_TRAP_EN defined, a misaligned request is a halfword with addr[0]=1 or a word with addr[1:0]!=00. In IDLE such a request SHALL:
  - go directly to DONE with no memory access;
  - assert misalign=1 for that DONE cycle;
  - assert no load_valid;
  - leave load_data unchanged.
REQ-035 Without MISALIGN_TRAP_EN, misalign SHALL be tied to 0 and the low address bits SHALL be ignored:
  - halfword: addr[0] is ignored;
  - word: addr[1:0] is ignored.

Verification
REQ-036 Memory word 0x40 = 0x8899AABB; signed byte load at 0x41 -> load_valid in the 4th cycle, load_data=0xFFFFFF99; stall=1 for the 3 prior cycles.
REQ-037 Same word; unsigned halfword load at 0x42 -> load_data=0x0000AABB; signed halfword load at 0x40 -> load_data=0xFFFF8899.
REQ-038 Byte store of 0x12 to 0x43 over 0x8899AABB -> exactly one mem_wr cycle with mem_addr=0x40 and mem_din=0x8899AA12.
REQ-039 Word store 0xDEADBEEF to 0x80 -> mem_wr in the cycle after accept, no mem_oe cycle, stall low in cycle 2.
REQ-040 Halfword store issued, rst pulsed during RD -> mem_wr never asserts, memory unchanged, state IDLE.
REQ-041 Word load at 0x42: with MISALIGN_TRAP_EN, misalign=1 in the cycle after accept and no mem_oe; without it, load_data = word at 0x40.
